// File: rtl/bnn_pe_array_param.sv
// Weight-stationary binary PE array: ROWS rows of DEPTH stored weight words,
// XNOR-popcount dot product against a streamed activation vector, saturating sums.
module bnn_pe_array_param #(
  parameter int ROWS   = 3,
  parameter int VEC_W  = 27,
  parameter int DEPTH  = 4,
  parameter int PSUM_W = 14
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start,
  input  logic                     reload_w,
  input  logic                     mode,
  input  logic [VEC_W-1:0]         data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ROWS*PSUM_W-1:0]   psum_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int NW     = ROWS * DEPTH;
  localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int ACNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TERM_W = $clog2(VEC_W + 1) + 1;
  localparam int SUM_W  = ((PSUM_W > TERM_W) ? PSUM_W : TERM_W) + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (PSUM_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_A, S_DRAIN, S_OUT} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_mode;
  logic                r_w_loaded;
  logic                r_s1_valid;
  logic                r_drain_cnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [ACNT_W-1:0]   r_acnt;
  logic [VEC_W-1:0]    r_wmem [NW];

  logic w_w_fire;
  logic w_a_fire;
  logic w_job_start;
  logic w_load_out;

  assign w_w_fire    = in_valid & r_in_ready & (r_state == S_LOAD_W);
  assign w_a_fire    = in_valid & r_in_ready & (r_state == S_LOAD_A);
  assign w_job_start = (r_state == S_IDLE) & start;
  assign w_load_out  = (r_state == S_DRAIN) & r_drain_cnt;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_mode      <= 1'b0;
      r_w_loaded  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_wcnt      <= '0;
      r_acnt      <= '0;
    end else begin
      r_s1_valid <= w_a_fire;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_wcnt     <= '0;
            r_acnt     <= '0;
            r_state    <= (reload_w || !r_w_loaded) ? S_LOAD_W : S_LOAD_A;
          end
        end
        S_LOAD_W: begin
          if (w_w_fire) begin
            if (r_wcnt == WCNT_W'(NW - 1)) begin
              r_wcnt     <= '0;
              r_w_loaded <= 1'b1;
              r_state    <= S_LOAD_A;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        S_LOAD_A: begin
          if (w_a_fire) begin
            if (r_acnt == ACNT_W'(DEPTH - 1)) begin
              r_acnt      <= '0;
              r_in_ready  <= 1'b0;
              r_drain_cnt <= 1'b0;
              r_state     <= S_DRAIN;
            end else begin
              r_acnt <= r_acnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // first cycle lets stage 2 absorb the last term, second presents the result
          r_drain_cnt <= 1'b1;
          if (r_drain_cnt) begin
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Weight contents are not reset; r_w_loaded alone marks them usable.
  always_ff @(posedge clk_in) begin
    if (w_w_fire) begin
      r_wmem[r_wcnt] <= data_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam logic [WCNT_W-1:0] BASE = WCNT_W'(gi * DEPTH);

      logic [WCNT_W-1:0]        w_ridx;
      logic [TERM_W-1:0]        w_pc;
      logic signed [TERM_W-1:0] w_term;
      logic signed [SUM_W-1:0]  w_sum;
      logic signed [TERM_W-1:0] r_term;
      logic signed [PSUM_W-1:0] r_acc;
      logic signed [PSUM_W-1:0] r_psum;
      logic                     r_sat;

      assign w_ridx = BASE + WCNT_W'(r_acnt);
      assign w_pc   = TERM_W'($countones(~(data_in ^ r_wmem[w_ridx])));
      // bipolar term 2*pc - VEC_W fits TERM_W even though 2*pc alone may wrap
      assign w_term = r_mode ? $signed(w_pc) : $signed((w_pc << 1) - TERM_W'(VEC_W));
      assign w_sum  = {{(SUM_W - PSUM_W){r_acc[PSUM_W-1]}}, r_acc}
                    + {{(SUM_W - TERM_W){r_term[TERM_W-1]}}, r_term};

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_term <= '0;
          r_acc  <= '0;
          r_psum <= '0;
          r_sat  <= 1'b0;
        end else begin
          if (w_a_fire) begin
            r_term <= w_term;
          end
          if (w_job_start) begin
            r_acc <= '0;
            r_sat <= 1'b0;
          end else if (r_s1_valid && !r_sat) begin
            if (w_sum > ACC_MAX) begin
              r_acc <= ACC_MAX[PSUM_W-1:0];
              r_sat <= 1'b1;
            end else if (w_sum < ACC_MIN) begin
              r_acc <= ACC_MIN[PSUM_W-1:0];
              r_sat <= 1'b1;
            end else begin
              r_acc <= w_sum[PSUM_W-1:0];
            end
          end
          if (w_load_out) begin
            r_psum <= r_acc;
          end
        end
      end

      assign psum_out[gi*PSUM_W +: PSUM_W] = r_psum;
    end
  endgenerate

endmodule

// File: tb/tb_bnn_pe_array_param.sv
// Bench for bnn_pe_array_param: default instance plus a PSUM_W=7 instance on shared
// stimulus, checked against a per-job arithmetic model of the dot products.
module tb_bnn_pe_array_param;
  localparam int ROWS  = 3;
  localparam int VEC_W = 27;
  localparam int DEPTH = 4;
  localparam int PW    = 14;
  localparam int PW7   = 7;
  localparam int NW    = ROWS * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, start, reload_w, mode, in_valid, out_ready;
  logic [VEC_W-1:0]     data_in;
  logic                 in_ready, out_valid, busy;
  logic                 in_ready7, out_valid7, busy7;
  logic [ROWS*PW-1:0]   psum;
  logic [ROWS*PW7-1:0]  psum7;

  bnn_pe_array_param #(.ROWS(ROWS), .VEC_W(VEC_W), .DEPTH(DEPTH), .PSUM_W(PW)) dut (
    .clk_in(clk), .rst_in(rst_n), .start(start), .reload_w(reload_w), .mode(mode),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready), .psum_out(psum),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  bnn_pe_array_param #(.ROWS(ROWS), .VEC_W(VEC_W), .DEPTH(DEPTH), .PSUM_W(PW7)) dut7 (
    .clk_in(clk), .rst_in(rst_n), .start(start), .reload_w(reload_w), .mode(mode),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready7), .psum_out(psum7),
    .out_valid(out_valid7), .out_ready(out_ready), .busy(busy7)
  );

  int total = 0;
  int bad   = 0;

  logic [VEC_W-1:0] job_w [NW];
  logic [VEC_W-1:0] job_a [DEPTH];
  logic [VEC_W-1:0] m_w   [NW];
  bit               m_loaded = 1'b0;
  int               exp_p  [ROWS];
  int               exp_p7 [ROWS];

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic int prow(input int r);
    logic signed [PW-1:0] v;
    v = psum[r*PW +: PW];
    return int'(v);
  endfunction

  function automatic int prow7(input int r);
    logic signed [PW7-1:0] v;
    v = psum7[r*PW7 +: PW7];
    return int'(v);
  endfunction

  // dot product from the rules: per-step term, signed sum clamped, sticky once clamped
  function automatic int model_row(input int r, input bit md, input int pw);
    int acc = 0;
    int mx, mn, t, s;
    bit sat = 1'b0;
    mx = (1 << (pw - 1)) - 1;
    mn = -(1 << (pw - 1));
    for (int k = 0; k < DEPTH; k++) begin
      t = $countones(~(job_a[k] ^ m_w[r*DEPTH + k]));
      if (!md) t = 2 * t - VEC_W;
      if (!sat) begin
        s = acc + t;
        if (s > mx) begin
          acc = mx; sat = 1'b1;
        end else if (s < mn) begin
          acc = mn; sat = 1'b1;
        end else begin
          acc = s;
        end
      end
    end
    return acc;
  endfunction

  // psum_out must match the model on every cycle the result is presented
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      for (int r = 0; r < ROWS; r++) begin
        chk($sformatf("psum_r%0d", r), prow(r), exp_p[r]);
        chk($sformatf("psum7_r%0d", r), prow7(r), exp_p7[r]);
      end
    end
  end

  task automatic send_word(input logic [VEC_W-1:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_job(input bit rl, input bit md, input bit stall, input int hold,
                         input int abort_at);
    bit do_w;
    int n = 0;
    do_w = rl || !m_loaded;
    if (do_w) begin
      for (int i = 0; i < NW; i++) m_w[i] = job_w[i];
      m_loaded = 1'b1;
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_p[r]  = model_row(r, md, PW);
      exp_p7[r] = model_row(r, md, PW7);
    end
    $display("job: reload=%0b mode=%0b stall=%0b hold=%0d weights=%0b exp=%0d,%0d,%0d",
             rl, md, stall, hold, do_w, exp_p[0], exp_p[1], exp_p[2]);
    start = 1'b1; reload_w = rl; mode = md;
    @(posedge clk); #1;
    start = 1'b0; reload_w = $urandom_range(0, 1); mode = $urandom_range(0, 1);
    for (int i = 0; i < (do_w ? NW : 0) + DEPTH; i++) begin
      if (abort_at > 0 && n == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        for (int r = 0; r < ROWS; r++) chk($sformatf("rst_psum_r%0d", r), prow(r), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_loaded = 1'b0;
        return;
      end
      if (stall && (i % 2 == 1)) begin
        in_valid = 1'b0;
        data_in  = VEC_W'($urandom);
        @(posedge clk); #1;
      end
      if (do_w && i < NW) send_word(job_w[i]);
      else send_word(job_a[i - (do_w ? NW : 0)]);
      n++;
    end
    in_valid = 1'b0;
    data_in  = VEC_W'($urandom);
    @(negedge clk);
    chk("in_ready_after_last", in_ready, 0);
    chk("out_valid_lat1", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("out_valid_lat2", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("out_valid_rise", out_valid, 1);
    chk("out_valid7_rise", out_valid7, 1);
    chk("busy_out", busy, 1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      in_valid  = 1'b1;
      data_in   = VEC_W'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      chk("out_valid_hold", out_valid, 1);
      chk("in_ready_hold", in_ready, 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_drop", out_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic pin(input int e0, input int e1, input int e2,
                     input int f0, input int f1, input int f2);
    chk("pin_r0", prow(0), e0);
    chk("pin_r1", prow(1), e1);
    chk("pin_r2", prow(2), e2);
    chk("pin7_r0", prow7(0), f0);
    chk("pin7_r1", prow7(1), f1);
    chk("pin7_r2", prow7(2), f2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; reload_w = 1'b0; mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    for (int r = 0; r < ROWS; r++) chk($sformatf("reset_psum_r%0d", r), prow(r), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NW; i++) job_w[i] = 27'h7FFFFFF;
    for (int k = 0; k < DEPTH; k++) job_a[k] = 27'h7FFFFFF;
    run_job(1'b1, 1'b0, 1'b0, 0, 0);
    pin(108, 108, 108, 63, 63, 63);

    for (int k = 0; k < DEPTH; k++) job_a[k] = '0;
    run_job(1'b0, 1'b0, 1'b0, 0, 0);
    pin(-108, -108, -108, -64, -64, -64);
    run_job(1'b0, 1'b1, 1'b0, 0, 0);
    pin(0, 0, 0, 0, 0, 0);

    for (int k = 0; k < DEPTH; k++) begin
      job_w[k]           = 27'h7FFFFFF;
      job_w[DEPTH + k]   = 27'h0;
      job_w[2*DEPTH + k] = 27'h5555555;
      job_a[k]           = 27'h7FFFFFF;
    end
    run_job(1'b1, 1'b0, 1'b0, 0, 0);
    pin(108, -108, 4, 63, -64, 4);
    run_job(1'b1, 1'b0, 1'b1, 5, 0);
    pin(108, -108, 4, 63, -64, 4);

    run_job(1'b1, 1'b1, 1'b0, 0, NW + 2);
    run_job(1'b0, 1'b0, 1'b0, 0, 0);
    pin(108, -108, 4, 63, -64, 4);

    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < NW; i++) job_w[i] = VEC_W'($urandom);
      for (int k = 0; k < DEPTH; k++) job_a[k] = VEC_W'($urandom);
      if (j % 4 == 3) for (int k = 0; k < DEPTH; k++) job_a[k] = ~job_w[k];
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_pe_array_param.md
Name: bnn_pe_array_param

Overview:
Parametrised successor to the fixed 3-row binary PE array. It holds ROWS weight-stationary rows of DEPTH binary weight words. It streams DEPTH binary activation words and, per row, accumulates an XNOR-popcount dot product over all words. Supports bipolar (±1) and unsigned popcount modes, weight reuse across jobs, valid/ready handshakes on both sides, and saturating partial sums. Sits between the activation/weight buffer and the BNN accumulation/threshold stage.

Parameters:
ROWS, 3, number of PE rows (output channels)
VEC_W, 27, bits per activation/weight word
DEPTH, 4, words per dot product (accumulation steps)
PSUM_W, 14, signed partial-sum width per row

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  asynchronous active-low reset
start  input  1  job start pulse, sampled only in IDLE
reload_w  input  1  sampled with start: 1 = load new weights, 0 = reuse stored weights
mode  input  1  sampled with start: 0 = bipolar, 1 = unsigned popcount
data_in  input  VEC_W  weight or activation word
in_valid  input  1  data_in valid
in_ready  output  1  block accepts data_in
psum_out  output  ROWS*PSUM_W  row r occupies bits [r*PSUM_W +: PSUM_W], signed
out_valid  output  1  psum_out valid
out_ready  input  1  downstream accepts psum_out
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; in_ready=0, out_valid=0, busy=0, psum_out=0. Accumulators, counters and the pipeline valid flag are cleared. Weight storage contents are invalidated: a weights_loaded flag clears.
- Transfer occurs on a rising edge with in_valid & in_ready, or out_valid & out_ready.
- FSM states: IDLE, LOAD_W, LOAD_A, DRAIN, OUT.
- IDLE:
  - start & (reload_w | !weights_loaded) -> LOAD_W.
  - start & !reload_w & weights_loaded -> LOAD_A.
  - mode is latched on start.
  - The accumulators clear on the start edge.
- LOAD_W:
  - in_ready=1.
  - Accepts ROWS*DEPTH words, row-major: row 0 words 0..DEPTH-1, then row 1, and so on.
  - A word counter wraps at ROWS*DEPTH.
  - After the last word, weights_loaded is set and the FSM goes to LOAD_A.
- LOAD_A:
  - in_ready=1.
  - Accepts DEPTH activation words; word k pairs with weight word k of every row.
  - Pipeline stage 1: the popcount of XNOR(a_k, w[r][k]) is registered for all rows.
  - Pipeline stage 2: the registered term is added into the row accumulator.
  - After the last word is accepted -> DRAIN.
- DRAIN:
  - in_ready=0.
  - Lasts exactly 2 cycles, emptying both pipeline stages.
  - Then -> OUT.
  - out_valid first rises 2 cycles after the edge that accepted the last activation.
- Per-step term:
  - Bipolar: 2*popcount - VEC_W, range [-VEC_W, VEC_W].
  - Popcount mode: popcount, range [0, VEC_W].
- Accumulation is signed, PSUM_W bits, saturating at +2^(PSUM_W-1)-1 and -2^(PSUM_W-1). Saturation is sticky within a job.
- OUT:
  - out_valid=1; psum_out is stable until the handshake.
  - On out_valid & out_ready -> IDLE, and out_valid drops on that edge.
  - psum_out holds its last value until the next job's result.
- Stalls: in_valid low during a load holds the counter and pipeline. Gaps between words are allowed and change neither the result nor the final latency.
- Ignored inputs: start is ignored outside IDLE. data_in is ignored whenever in_ready=0.
- Back-to-back jobs: start may be asserted in the same cycle the output handshake completes, but is acted on only once IDLE is reached, on the next edge.
- Reset mid-operation: the job is aborted, no output is produced, and weights must be reloaded.

Test Plan:
- Defaults, reload_w=1, bipolar; all weights and activations 27'h7FFFFFF. Expected: each row psum=+108; out_valid 2 cycles after the 4th activation.
- Same weights, reload_w=0, activations all 0. Expected: no weight phase (in_ready high for exactly 4 accepted words); psums=-108 bipolar, then 0 in a rerun with mode=1.
- Row weights 0x7FFFFFF, 0, alternating 0x5555555; activations 0x7FFFFFF. Expected bipolar psums: +108, -108, 4*(2*14-27)=+4.
- in_valid toggling 1-0-1-0 during both loads, and out_ready held low 5 cycles. Expected: results identical to the no-stall run; psum_out and out_valid stable throughout the 5-cycle hold.
- PSUM_W=7 override, all-ones case. Expected: +63 saturated; all-zero activations give -64.
- rst_in pulsed low mid LOAD_A, then start with reload_w=0. Expected: outputs 0 immediately on reset; the block enters LOAD_W because weights_loaded was cleared.
